// File: rtl/tlm_pkg.sv
// rtl/tlm_pkg.sv - shared state type and header bytes for the telemetry packetiser
package tlm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT
  } tlm_state_t;

  localparam logic [7:0] HDR0 = 8'hAA;
  localparam logic [7:0] HDR1 = 8'h55;

endpackage

// File: rtl/tlm_period_timer.sv
// rtl/tlm_period_timer.sv - free-running packet period timer with a one-cycle tick
module tlm_period_timer #(
  parameter int PERIOD = 1048576
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CNT_W-1:0] TOP = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] count;

  // Count 0..PERIOD-1 and wrap; reset parks on TOP so the first tick follows release
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= TOP;
    end else if (count == TOP) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  assign tick = (count == TOP);

endmodule

// File: rtl/telemetry_pkt_gen.sv
// rtl/telemetry_pkt_gen.sv - telemetry packetiser for a byte UART; TLM_CHKSUM_EN appends a checksum byte
module telemetry_pkt_gen
  import tlm_pkg::*;
#(
  parameter int NUM_CH = 3,
  parameter int DATA_W = 12,
  parameter int PERIOD = 1048576
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     send_req,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  input  logic                     tx_done,
  output logic                     trmt,
  output logic [7:0]               tx_data,
  output logic                     busy,
  output logic                     pkt_done,
  output logic                     overrun
);

`ifdef TLM_CHKSUM_EN
  localparam int PKT_LEN = 3 + 2 * NUM_CH;
`else
  localparam int PKT_LEN = 2 + 2 * NUM_CH;
`endif
  localparam int IDX_W = $clog2(PKT_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_LEN - 1);

  // Byte i of the packet for i >= 2: high then low half of channel (i-2)/2
  function automatic logic [7:0] payload_byte(input logic [NUM_CH*DATA_W-1:0] s,
                                              input logic [IDX_W-1:0] i);
    logic [IDX_W-1:0] p;
    logic [15:0]      v;
    p = i - IDX_W'(2);
    v = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (int'(p >> 1) == c) begin
        v = 16'(s[c*DATA_W +: DATA_W]);
      end
    end
    return p[0] ? v[7:0] : v[15:8];
  endfunction

  tlm_state_t              state, state_d;
  logic [IDX_W-1:0]        idx, idx_d, nxt_idx;
  logic [7:0]              tx_data_d, payload;
  logic                    busy_d, pkt_done_d, overrun_d;
  logic [NUM_CH*DATA_W-1:0] snap, snap_d;
  logic                    tick, start;
`ifdef TLM_CHKSUM_EN
  logic [7:0]              sum, sum_d;
`endif

  tlm_period_timer #(.PERIOD(PERIOD)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign start   = (tick & en) | send_req;
  assign nxt_idx = idx + IDX_W'(1);
  assign payload = payload_byte(snap, nxt_idx);
  assign trmt    = (state == SEND);

  // Next-state and next-output decode; starts during busy or the pkt_done cycle are dropped
  always_comb begin
    state_d    = state;
    idx_d      = idx;
    tx_data_d  = tx_data;
    busy_d     = busy;
    pkt_done_d = 1'b0;
    overrun_d  = overrun;
    snap_d     = snap;
`ifdef TLM_CHKSUM_EN
    sum_d      = sum;
`endif
    if (start && (busy || pkt_done)) begin
      overrun_d = 1'b1;
    end
    case (state)
      IDLE: begin
        if (start && !pkt_done) begin
          snap_d    = ch_data;
          tx_data_d = HDR0;
          busy_d    = 1'b1;
          idx_d     = '0;
          state_d   = SEND;
`ifdef TLM_CHKSUM_EN
          sum_d     = 8'h00;
`endif
        end
      end
      SEND: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (tx_done) begin
          if (idx == LAST_IDX) begin
            pkt_done_d = 1'b1;
            busy_d     = 1'b0;
            idx_d      = '0;
            state_d    = IDLE;
          end else begin
            idx_d   = nxt_idx;
            state_d = SEND;
            if (nxt_idx == IDX_W'(1)) begin
              tx_data_d = HDR1;
            end
`ifdef TLM_CHKSUM_EN
            else if (nxt_idx == LAST_IDX) begin
              tx_data_d = 8'h00 - sum;
            end
`endif
            else begin
              tx_data_d = payload;
`ifdef TLM_CHKSUM_EN
              sum_d     = sum + payload;
`endif
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Register all state and outputs; reset abandons any packet in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      tx_data  <= 8'h00;
      busy     <= 1'b0;
      pkt_done <= 1'b0;
      overrun  <= 1'b0;
      snap     <= '0;
`ifdef TLM_CHKSUM_EN
      sum      <= 8'h00;
`endif
    end else begin
      state    <= state_d;
      idx      <= idx_d;
      tx_data  <= tx_data_d;
      busy     <= busy_d;
      pkt_done <= pkt_done_d;
      overrun  <= overrun_d;
      snap     <= snap_d;
`ifdef TLM_CHKSUM_EN
      sum      <= sum_d;
`endif
    end
  end

endmodule

// File: tb/tb_telemetry_pkt_gen.sv
// tb/tb_telemetry_pkt_gen.sv - scoreboard bench for telemetry_pkt_gen against a timing/packet reference model
module tb_telemetry_pkt_gen;

  localparam int NUM_CH = 3;
  localparam int DATA_W = 12;
  localparam int PERIOD = 64;
  localparam int MAXC   = 6000;
`ifdef TLM_CHKSUM_EN
  localparam int PKT_L = 3 + 2 * NUM_CH;
`else
  localparam int PKT_L = 2 + 2 * NUM_CH;
`endif

  logic                     clk = 1'b0;
  logic                     rst, en, send_req, tx_done;
  logic [NUM_CH*DATA_W-1:0] ch_data, cur;
  logic                     trmt, busy, pkt_done, overrun;
  logic [7:0]               tx_data;

  telemetry_pkt_gen #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .PERIOD(PERIOD)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .send_req (send_req),
    .ch_data  (ch_data),
    .tx_done  (tx_done),
    .trmt     (trmt),
    .tx_data  (tx_data),
    .busy     (busy),
    .pkt_done (pkt_done),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  // UART model: tx_done rises ud cycles after trmt, cleared by trmt
  int ud = 10;
  int ucnt = 0;
  initial tx_done = 1'b0;
  always @(negedge clk) begin
    if (trmt === 1'b1) begin
      tx_done = 1'b0;
      ucnt = ud;
    end else if (ucnt > 0) begin
      ucnt--;
      if (ucnt == 0) tx_done = 1'b1;
    end
  end

  typedef struct {
    int         cyc;
    logic [7:0] b;
  } tev_t;

  tev_t exp_q[$];
  int   done_q[$];
  bit   exp_busy[MAXC];
  bit   exp_ov[MAXC];
  bit   rst_hist[MAXC];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   last_rst = 0;
  int   busy_until = -1;
  int   last_start = -1;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  function automatic bit is_tick(input int n);
    return (n > last_rst) && (((n - last_rst - 1) % PERIOD) == 0);
  endfunction

  // Reference packet: header, then hi/lo byte of each channel, optional checksum
  task automatic accept(input int s);
    int   bytes[$];
    int   sum, v, dur;
    tev_t e;
    sum = 0;
    bytes.push_back(8'hAA);
    bytes.push_back(8'h55);
    for (int k = 0; k < NUM_CH; k++) begin
      v = int'(ch_data[k*DATA_W +: DATA_W]);
      bytes.push_back(v / 256);
      bytes.push_back(v % 256);
      sum += v / 256 + v % 256;
    end
`ifdef TLM_CHKSUM_EN
    bytes.push_back((256 - sum % 256) % 256);
`endif
    for (int j = 0; j < bytes.size(); j++) begin
      e.cyc = s + 1 + j * (ud + 1);
      e.b = 8'(bytes[j]);
      exp_q.push_back(e);
    end
    dur = PKT_L * (ud + 1);
    for (int m = s + 1; m <= s + dur && m < MAXC; m++) exp_busy[m] = 1'b1;
    done_q.push_back(s + dur + 1);
    busy_until = s + dur + 1;
    last_start = s;
  endtask

  task automatic model_eval();
    if (rst) begin
      rst_hist[cyc] = 1'b1;
      last_rst = cyc;
      busy_until = cyc;
      for (int m = cyc + 1; m < MAXC; m++) begin
        exp_busy[m] = 1'b0;
        exp_ov[m] = 1'b0;
      end
      while (exp_q.size() > 0 && exp_q[$].cyc > cyc) void'(exp_q.pop_back());
      while (done_q.size() > 0 && done_q[$] > cyc) void'(done_q.pop_back());
    end else if ((is_tick(cyc) && en) || send_req) begin
      if (cyc <= busy_until) begin
        for (int m = cyc + 1; m < MAXC; m++) exp_ov[m] = 1'b1;
      end else begin
        accept(cyc);
      end
    end
  endtask

  task automatic drive(input logic r, input logic e, input logic s, input logic [NUM_CH*DATA_W-1:0] d);
    @(posedge clk);
    #1;
    cyc++;
    rst = r;
    en = e;
    send_req = s;
    ch_data = d;
    model_eval();
  endtask

  // Monitor: pops expected events when due and compares every cycle's outputs
  always @(negedge clk) begin
    if (cyc >= 2 && cyc < MAXC) begin
      bit exp_t, exp_d;
      exp_t = (exp_q.size() > 0 && exp_q[0].cyc == cyc);
      chk("trmt", {7'd0, trmt}, {7'd0, exp_t});
      if (exp_t) begin
        if (trmt === 1'b1) chk("tx_data", tx_data, exp_q[0].b);
        void'(exp_q.pop_front());
      end
      exp_d = (done_q.size() > 0 && done_q[0] == cyc);
      chk("pkt_done", {7'd0, pkt_done}, {7'd0, exp_d});
      if (exp_d) void'(done_q.pop_front());
      chk("busy", {7'd0, busy}, {7'd0, exp_busy[cyc]});
      chk("overrun", {7'd0, overrun}, {7'd0, exp_ov[cyc]});
      if (rst_hist[cyc-1]) chk("tx_data_after_rst", tx_data, 8'h00);
    end
  end

  task automatic do_reset(input int n);
    repeat (n) drive(1'b1, 1'b0, 1'b0, cur);
  endtask

  function automatic logic [NUM_CH*DATA_W-1:0] rnd_data();
    return (NUM_CH*DATA_W)'({$urandom(), $urandom()});
  endfunction

  initial begin
    int s;
    rst = 1'b1;
    en = 1'b0;
    send_req = 1'b0;
    cur = {12'h0C3, 12'h5A1, 12'hF0F};
    ch_data = cur;

    // Known packet after reset, mid-packet data change, periodic overrun
    ud = 10;
    do_reset(3);
    drive(1'b0, 1'b1, 1'b0, cur);
    s = last_start;
    for (int i = 0; i < 130; i++) begin
      if (cyc == s + 2) cur[11:0] = 12'h123;
      drive(1'b0, 1'b1, 1'b0, cur);
    end

    // Fast UART: periodic packets with no overrun, data changing every cycle
    ud = 5;
    do_reset(2);
    for (int i = 0; i < 300; i++) begin
      cur = rnd_data();
      drive(1'b0, 1'b1, 1'b0, cur);
    end

    // en low, one-shot request, start in pkt_done cycle, then back-to-back start
    ud = 10;
    do_reset(2);
    for (int i = 0; i < 200; i++) drive(1'b0, 1'b0, 1'b0, cur);
    cur = rnd_data();
    drive(1'b0, 1'b0, 1'b1, cur);
    for (int i = 0; i < 300 && cyc + 1 < busy_until; i++) drive(1'b0, 1'b0, 1'b0, cur);
    cur = rnd_data();
    drive(1'b0, 1'b0, 1'b1, cur);
    cur = rnd_data();
    drive(1'b0, 1'b0, 1'b1, cur);
    for (int i = 0; i < 120; i++) drive(1'b0, 1'b0, 1'b0, cur);

    // send_req coinciding with a tick while en is low
    do_reset(2);
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b0, 1'b0, cur);
    for (int i = 0; i < 100 && !is_tick(cyc + 1); i++) drive(1'b0, 1'b0, 1'b0, cur);
    cur = rnd_data();
    drive(1'b0, 1'b0, 1'b1, cur);
    for (int i = 0; i < 120; i++) drive(1'b0, 1'b0, 1'b0, cur);

    // Slow UART: ticks land while busy
    ud = 20;
    do_reset(2);
    for (int i = 0; i < 420; i++) begin
      cur = rnd_data();
      drive(1'b0, 1'b1, 1'b0, cur);
    end

    // Reset during the WAIT of byte 4, then a fresh packet
    ud = 10;
    do_reset(2);
    cur = rnd_data();
    drive(1'b0, 1'b1, 1'b0, cur);
    s = last_start;
    for (int i = 0; i < 100 && cyc + 1 < s + 1 + 4 * 11 + 3; i++) drive(1'b0, 1'b1, 1'b0, cur);
    drive(1'b1, 1'b1, 1'b0, cur);
    for (int i = 0; i < 120; i++) drive(1'b0, 1'b1, 1'b0, cur);

    // Randomized segments
    for (int seg = 0; seg < 4; seg++) begin
      ud = $urandom_range(2, 12);
      do_reset(2);
      for (int i = 0; i < 400; i++) begin
        cur = rnd_data();
        drive(1'b0, ($urandom_range(0, 7) != 0), ($urandom_range(0, 39) == 0), cur);
      end
    end

    for (int i = 0; i < 250; i++) drive(1'b0, 1'b0, 1'b0, cur);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
